// File: rtl/adc_vad_framer.sv
// Voice-activity framer: removes ADC DC offset, sums per-frame |amplitude| energy
// and tracks speech with attack/hangover hysteresis.
module adc_vad_framer #(
   parameter int FRAME_LEN     = 256,
   parameter int DC_SHIFT      = 8,
   parameter int ATTACK_FRAMES = 2,
   parameter int HANG_FRAMES   = 4,
   parameter int ENERGY_W      = 12 + $clog2(FRAME_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [11:0]         sample_in,
   input  logic                sample_valid,
   input  logic [ENERGY_W-1:0] threshold,
   output logic [ENERGY_W-1:0] frame_energy,
   output logic                frame_valid,
   output logic                speech_active,
   output logic                speech_start,
   output logic                speech_end
);

   localparam int DC_W  = 13 + DC_SHIFT;
   localparam int FC_W  = $clog2(FRAME_LEN);
   localparam int MAXF  = (ATTACK_FRAMES > HANG_FRAMES) ? ATTACK_FRAMES : HANG_FRAMES;
   localparam int CNT_W = $clog2(MAXF + 1);

   typedef enum logic [1:0] {
      ST_SILENCE = 2'd0,
      ST_ONSET   = 2'd1,
      ST_SPEECH  = 2'd2,
      ST_HANG    = 2'd3
   } state_t;

   logic [DC_W-1:0]     dc_acc_q, dc_acc_d;
   logic [12:0]         dc_est_s, centered_s;
   logic [11:0]         mag_s, mag_q;
   logic                mag_valid_q;
   logic [ENERGY_W-1:0] acc_q, frame_energy_q;
   logic [FC_W-1:0]     count_q;
   logic                frame_done_q, frame_valid_q;
   logic                loud_s;
   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                speech_active_q, speech_start_q, speech_end_q;

   // DC estimate, centering and magnitude; the estimate never exceeds 4095 so 13 bits suffice
   always_comb begin
      dc_est_s   = dc_acc_q[DC_SHIFT +: 13];
      centered_s = {1'b0, sample_in} - dc_est_s;
      if (centered_s[12]) begin
         mag_s = 12'(13'd0 - centered_s);
      end else begin
         mag_s = centered_s[11:0];
      end
      dc_acc_d = dc_acc_q + DC_W'(sample_in) - DC_W'(dc_est_s);
   end

   // Stage 1 registers: DC tracker and magnitude pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dc_acc_q    <= DC_W'(12'd2048) << DC_SHIFT;
         mag_q       <= 12'd0;
         mag_valid_q <= 1'b0;
      end else begin
         mag_valid_q <= sample_valid;
         if (sample_valid) begin
            dc_acc_q <= dc_acc_d;
            mag_q    <= mag_s;
         end
      end
   end

   // Stage 2: frame energy accumulation; frame_valid trails the energy update by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q          <= '0;
         count_q        <= '0;
         frame_energy_q <= '0;
         frame_done_q   <= 1'b0;
         frame_valid_q  <= 1'b0;
      end else begin
         frame_done_q  <= 1'b0;
         frame_valid_q <= frame_done_q;
         if (mag_valid_q) begin
            if (count_q == FC_W'(FRAME_LEN - 1)) begin
               frame_energy_q <= acc_q + ENERGY_W'(mag_q);
               acc_q          <= '0;
               count_q        <= '0;
               frame_done_q   <= 1'b1;
            end else begin
               acc_q   <= acc_q + ENERGY_W'(mag_q);
               count_q <= count_q + FC_W'(1);
            end
         end
      end
   end

   // Loudness decision against the live threshold
   always_comb begin
      loud_s = (frame_energy_q > threshold);
   end

   // Voice-activity FSM with registered activity flag and one-cycle pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_SILENCE;
         cnt_q           <= '0;
         speech_active_q <= 1'b0;
         speech_start_q  <= 1'b0;
         speech_end_q    <= 1'b0;
      end else begin
         speech_start_q <= 1'b0;
         speech_end_q   <= 1'b0;
         if (frame_valid_q) begin
            case (state_q)
               ST_SILENCE: begin
                  if (loud_s) begin
                     if (ATTACK_FRAMES == 1) begin
                        state_q         <= ST_SPEECH;
                        cnt_q           <= '0;
                        speech_active_q <= 1'b1;
                        speech_start_q  <= 1'b1;
                     end else begin
                        state_q <= ST_ONSET;
                        cnt_q   <= CNT_W'(1);
                     end
                  end
               end
               ST_ONSET: begin
                  if (!loud_s) begin
                     state_q <= ST_SILENCE;
                     cnt_q   <= '0;
                  end else if (cnt_q + CNT_W'(1) >= CNT_W'(ATTACK_FRAMES)) begin
                     state_q         <= ST_SPEECH;
                     cnt_q           <= '0;
                     speech_active_q <= 1'b1;
                     speech_start_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_SPEECH: begin
                  if (!loud_s) begin
                     if (HANG_FRAMES == 1) begin
                        state_q         <= ST_SILENCE;
                        cnt_q           <= '0;
                        speech_active_q <= 1'b0;
                        speech_end_q    <= 1'b1;
                     end else begin
                        state_q <= ST_HANG;
                        cnt_q   <= CNT_W'(1);
                     end
                  end
               end
               ST_HANG: begin
                  if (loud_s) begin
                     state_q <= ST_SPEECH;
                     cnt_q   <= '0;
                  end else if (cnt_q + CNT_W'(1) >= CNT_W'(HANG_FRAMES)) begin
                     state_q         <= ST_SILENCE;
                     cnt_q           <= '0;
                     speech_active_q <= 1'b0;
                     speech_end_q    <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_q         <= ST_SILENCE;
                  cnt_q           <= '0;
                  speech_active_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign frame_energy  = frame_energy_q;
   assign frame_valid   = frame_valid_q;
   assign speech_active = speech_active_q;
   assign speech_start  = speech_start_q;
   assign speech_end    = speech_end_q;

endmodule

// File: tb/tb_adc_vad_framer.sv
// Bench for adc_vad_framer: small-frame instance for framing/VAD behaviour, 256-sample
// instance for accumulator range; expectations come from an arithmetic reference model.
module tb_adc_vad_framer;

   localparam int FL   = 4;
   localparam int ATT  = 2;
   localparam int HANG = 2;
   localparam int EW   = 12 + $clog2(FL);
   localparam int FL2  = 256;
   localparam int EW2  = 12 + $clog2(FL2);
   localparam int DS   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [11:0]   sample_in = 12'd0;
   logic          sample_valid = 1'b0;
   logic [EW-1:0] threshold = '0;
   logic [EW-1:0] frame_energy;
   logic          frame_valid, speech_active, speech_start, speech_end;

   logic [11:0]    s2_in = 12'd0;
   logic           s2_valid = 1'b0;
   logic [EW2-1:0] thr2 = '0;
   logic [EW2-1:0] e2;
   logic           fv2, act2, st2, en2;

   int checks = 0;
   int passed = 0;

   int m_dc;
   bit m_speech;
   int m_loud_run, m_quiet_run;

   always #5 clk = ~clk;

   adc_vad_framer #(.FRAME_LEN(FL), .DC_SHIFT(DS), .ATTACK_FRAMES(ATT), .HANG_FRAMES(HANG)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .threshold(threshold), .frame_energy(frame_energy), .frame_valid(frame_valid),
      .speech_active(speech_active), .speech_start(speech_start), .speech_end(speech_end));

   adc_vad_framer #(.FRAME_LEN(FL2), .DC_SHIFT(DS), .ATTACK_FRAMES(ATT), .HANG_FRAMES(HANG)) dut2 (
      .clk(clk), .rst(rst), .sample_in(s2_in), .sample_valid(s2_valid),
      .threshold(thr2), .frame_energy(e2), .frame_valid(fv2),
      .speech_active(act2), .speech_start(st2), .speech_end(en2));

   // Reference: one DC-tracked sample, straight from the arithmetic rules
   task automatic model_sample(inout int dc, input int x, output int mag);
      int est, c;
      est = dc >>> DS;
      c   = x - est;
      mag = (c < 0) ? -c : c;
      dc  = dc + x - est;
   endtask

   // Reference VAD expressed as runs of consecutive loud/quiet frames
   task automatic model_eval(input int e, output bit st, output bit en);
      bit loud;
      loud = (e > int'(threshold));
      st = 1'b0;
      en = 1'b0;
      if (!m_speech) begin
         m_loud_run = loud ? m_loud_run + 1 : 0;
         if (m_loud_run == ATT) begin
            m_speech = 1'b1; st = 1'b1; m_loud_run = 0; m_quiet_run = 0;
         end
      end else begin
         m_quiet_run = loud ? 0 : m_quiet_run + 1;
         if (m_quiet_run == HANG) begin
            m_speech = 1'b0; en = 1'b1; m_quiet_run = 0; m_loud_run = 0;
         end
      end
   endtask

   task automatic model_reset();
      m_dc = 2048 << DS;
      m_speech = 1'b0;
      m_loud_run = 0;
      m_quiet_run = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      sample_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // Drives one frame (optional random gaps) and records what the DUT does afterwards
   task automatic run_frame(input int s[FL], input int gmax,
                            output int lat, output int en, output int fvn,
                            output int stn, output int enn, output bit act,
                            output int exp_e, output bit exp_st, output bit exp_en, output bit exp_act);
      int mag, g;
      lat = -1; en = -1; fvn = 0; stn = 0; enn = 0; exp_e = 0;
      for (int i = 0; i < FL; i++) begin
         model_sample(m_dc, s[i], mag);
         exp_e += mag;
         sample_in = 12'(s[i]);
         sample_valid = 1'b1;
         @(posedge clk); #1;
         sample_valid = 1'b0;
         if (i < FL - 1) begin
            g = $urandom_range(gmax, 0);
            repeat (g) begin @(posedge clk); #1; end
         end
      end
      model_eval(exp_e, exp_st, exp_en);
      exp_act = m_speech;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (frame_valid) begin
            fvn++;
            if (lat < 0) begin lat = k; en = int'(frame_energy); end
         end
         if (speech_start) stn++;
         if (speech_end) enn++;
      end
      act = speech_active;
   endtask

   int loud_f[FL]  = '{2148, 1948, 2148, 1948};
   int quiet_f[FL] = '{2048, 2048, 2048, 2048};

   task automatic test_reset();
      #3;
      checks++;
      if ({frame_valid, speech_active, speech_start, speech_end} !== 4'b0000)
         $display("FAIL reset_flags: got %b want 0000", {frame_valid, speech_active, speech_start, speech_end});
      else passed++;
      checks++;
      if (frame_energy !== '0) $display("FAIL reset_energy: got %0d want 0", frame_energy);
      else passed++;
      #10 rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_dc_zero();
      int lat, en, fvn, stn, enn, ee; bit act, est, een, eact;
      do_reset();
      run_frame(quiet_f, 0, lat, en, fvn, stn, enn, act, ee, est, een, eact);
      checks++; if (lat !== 2) $display("FAIL dc_latency: got %0d want 2", lat); else passed++;
      checks++; if (en !== ee) $display("FAIL dc_energy: got %0d want %0d", en, ee); else passed++;
      checks++; if (fvn !== 1) $display("FAIL dc_pulses: got %0d want 1", fvn); else passed++;
      checks++; if (act !== 1'b0) $display("FAIL dc_active: got %b want 0", act); else passed++;
   endtask

   task automatic test_energy();
      int lat, en, fvn, stn, enn, ee; bit act, est, een, eact;
      do_reset();
      threshold = EW'(1000);
      run_frame(loud_f, 0, lat, en, fvn, stn, enn, act, ee, est, een, eact);
      checks++; if (en !== 400) $display("FAIL energy_400: got %0d want 400", en); else passed++;
      checks++; if (en !== ee) $display("FAIL energy_model: got %0d want %0d", en, ee); else passed++;
      checks++; if (fvn !== 1) $display("FAIL energy_pulses: got %0d want 1", fvn); else passed++;
   endtask

   // Runs a loud(1)/quiet(0) frame sequence, checking every frame against the model
   task automatic run_seq(input string name, input int n, input bit pat[8], input int gmax);
      int lat, en, fvn, stn, enn, ee; bit act, est, een, eact;
      int f[FL];
      for (int j = 0; j < n; j++) begin
         f = pat[j] ? loud_f : quiet_f;
         run_frame(f, gmax, lat, en, fvn, stn, enn, act, ee, est, een, eact);
         checks++; if (en !== ee) $display("FAIL %s_energy[%0d]: got %0d want %0d", name, j, en, ee); else passed++;
         checks++; if (stn !== int'(est)) $display("FAIL %s_start[%0d]: got %0d want %0d", name, j, stn, est); else passed++;
         checks++; if (enn !== int'(een)) $display("FAIL %s_end[%0d]: got %0d want %0d", name, j, enn, een); else passed++;
         checks++; if (act !== eact) $display("FAIL %s_active[%0d]: got %b want %b", name, j, act, eact); else passed++;
      end
   endtask

   task automatic test_attack_hang();
      bit p[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      threshold = EW'(100);
      run_seq("attack_hang", 6, p, 0);
   endtask

   task automatic test_onset_abort();
      bit p[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      threshold = EW'(100);
      run_seq("onset_abort", 4, p, 1);
   endtask

   task automatic test_threshold_equal();
      bit p[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      do_reset();
      threshold = EW'(400);
      run_seq("thr_equal", 3, p, 0);
   endtask

   task automatic test_midframe_reset();
      int lat, en, fvn, stn, enn, ee; bit act, est, een, eact;
      do_reset();
      threshold = EW'(100);
      run_frame(loud_f, 0, lat, en, fvn, stn, enn, act, ee, est, een, eact);
      run_frame(loud_f, 0, lat, en, fvn, stn, enn, act, ee, est, een, eact);
      checks++; if (act !== 1'b1) $display("FAIL mid_pre_active: got %b want 1", act); else passed++;
      for (int i = 0; i < 2; i++) begin
         sample_in = 12'(loud_f[i]);
         sample_valid = 1'b1;
         @(posedge clk); #1;
         sample_valid = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (speech_active !== 1'b0) $display("FAIL mid_async_active: got %b want 0", speech_active); else passed++;
      checks++; if (frame_energy !== '0) $display("FAIL mid_async_energy: got %0d want 0", frame_energy); else passed++;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      run_frame(loud_f, 0, lat, en, fvn, stn, enn, act, ee, est, een, eact);
      checks++; if (lat !== 2) $display("FAIL mid_latency: got %0d want 2", lat); else passed++;
      checks++; if (en !== ee) $display("FAIL mid_energy: got %0d want %0d", en, ee); else passed++;
   endtask

   task automatic test_random();
      int lat, en, fvn, stn, enn, ee; bit act, est, een, eact;
      int f[FL];
      int a;
      bit loud;
      do_reset();
      threshold = EW'(100);
      for (int j = 0; j < 16; j++) begin
         loud = ($urandom_range(2, 0) != 0);
         for (int i = 0; i < FL; i++) begin
            a = loud ? int'($urandom_range(600, 150)) : int'($urandom_range(6, 0)) - 3;
            f[i] = (i % 2 == 0) ? 2048 + a : 2048 - a;
         end
         run_frame(f, 3, lat, en, fvn, stn, enn, act, ee, est, een, eact);
         checks++; if (lat !== 2) $display("FAIL rnd_latency[%0d]: got %0d want 2", j, lat); else passed++;
         checks++; if (en !== ee) $display("FAIL rnd_energy[%0d]: got %0d want %0d", j, en, ee); else passed++;
         checks++; if (stn !== int'(est)) $display("FAIL rnd_start[%0d]: got %0d want %0d", j, stn, est); else passed++;
         checks++; if (enn !== int'(een)) $display("FAIL rnd_end[%0d]: got %0d want %0d", j, enn, een); else passed++;
         checks++; if (act !== eact) $display("FAIL rnd_active[%0d]: got %b want %b", j, act, eact); else passed++;
      end
   endtask

   task automatic test_wide();
      int dc2, mag, ee, lat, en;
      dc2 = 2048 << DS;
      ee = 0;
      lat = -1;
      en = -1;
      for (int i = 0; i < FL2; i++) begin
         model_sample(dc2, (i % 2 == 0) ? 0 : 4095, mag);
         ee += mag;
         s2_in = (i % 2 == 0) ? 12'd0 : 12'd4095;
         s2_valid = 1'b1;
         @(posedge clk); #1;
      end
      s2_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (fv2 && lat < 0) begin lat = k; en = int'(e2); end
      end
      checks++; if (lat !== 2) $display("FAIL wide_latency: got %0d want 2", lat); else passed++;
      checks++; if (en !== ee) $display("FAIL wide_energy: got %0d want %0d", en, ee); else passed++;
      checks++; if (en > FL2 * 4095 || en < 0) $display("FAIL wide_bound: got %0d want <= %0d", en, FL2 * 4095); else passed++;
   endtask

   initial begin
      test_reset();
      test_dc_zero();
      test_energy();
      test_attack_hang();
      test_onset_abort();
      test_threshold_equal();
      test_midframe_reset();
      test_random();
      test_wide();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/adc_vad_framer.md
Name: adc_vad_framer

Overview:
- Downstream consumer of the AD7991 ADC interface; takes one 12-bit microphone channel plus a per-sample valid strobe.
- Removes the DC offset, accumulates per-frame absolute-amplitude energy, and runs a voice-activity state machine with attack and hangover.
- Outputs gate the later feature-extraction and recognition stages.

Parameters:
- FRAME_LEN, 256, samples per frame; power of two, ≥2.
- DC_SHIFT, 8, IIR DC-estimator shift (time constant 2^DC_SHIFT samples).
- ATTACK_FRAMES, 2, consecutive loud frames needed to declare speech (≥1).
- HANG_FRAMES, 4, consecutive quiet frames needed to end speech (≥1).
- ENERGY_W, 12+$clog2(FRAME_LEN), energy accumulator width (derived; do not override).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- sample_in, input, 12, ADC code, straight binary 0..4095.
- sample_valid, input, 1, single-cycle strobe; may be high on consecutive cycles.
- threshold, input, ENERGY_W, speech energy threshold; sampled only at frame evaluation.
- frame_energy, output, ENERGY_W, sum of |centered sample| over the last completed frame.
- frame_valid, output, 1, one-cycle pulse when frame_energy updates.
- speech_active, output, 1, high in SPEECH and HANGOVER states.
- speech_start, output, 1, one-cycle pulse on entry to SPEECH from ONSET/SILENCE.
- speech_end, output, 1, one-cycle pulse on HANGOVER→SILENCE.

Behaviour:
- Reset (async, active-high) clears all state:
  - dc_acc = 2048<<DC_SHIFT; sample count = 0; accumulator = 0; state = SILENCE; counters = 0.
  - All outputs = 0.
- Stage 1, on a cycle with sample_valid=1:
  - dc_est = dc_acc>>DC_SHIFT.
  - centered = sample_in − dc_est, 13-bit signed.
  - mag = |centered|, 12 bits unsigned (max 4095, no saturation needed).
  - dc_acc ← dc_acc + sample_in − dc_est.
  - mag and its valid are registered.
- Stage 2, on a cycle with registered valid=1:
  - acc ← acc + mag.
  - On the FRAME_LEN-th sample: frame_energy ← acc + mag, acc ← 0, count ← 0, frame_valid=1 on the next cycle.
  - frame_valid therefore rises exactly 2 cycles after the clock edge sampling the frame's last sample_valid.
- No overflow: the worst case FRAME_LEN·4095 fits in ENERGY_W.
- Loud frame: frame_energy > threshold (strictly greater). Evaluated in the cycle frame_valid=1; state and pulses update on the following edge.
- FSM transitions (cnt = frame counter):
  - SILENCE: loud → ONSET with cnt=1, or directly to SPEECH with speech_start if ATTACK_FRAMES=1. Quiet → stay.
  - ONSET: loud → cnt+1; on reaching ATTACK_FRAMES go to SPEECH and pulse speech_start. Quiet → SILENCE, cnt=0.
  - SPEECH: quiet → HANGOVER with cnt=1, or directly to SILENCE with speech_end if HANG_FRAMES=1. Loud → stay.
  - HANGOVER: loud → SPEECH, cnt=0, no pulse. Quiet → cnt+1; on reaching HANG_FRAMES go to SILENCE and pulse speech_end.
- speech_start and speech_end coincide with the edge where speech_active changes; each is high for exactly one cycle.
- Gaps between samples are arbitrary; state holds while sample_valid=0.
- Reset mid-frame discards the partial frame; the next frame starts at sample 1.

Test Plan:
- Reset, then FRAME_LEN=4, constant sample_in=2048 ×4 → frame_valid once, 2 cycles after the last strobe; frame_energy=0; speech_active stays 0.
- FRAME_LEN=4, DC_SHIFT=8, samples 2148,1948,2148,1948 back-to-back → frame_energy=400; frame_valid a single pulse.
- threshold=100, ATTACK=2, HANG=2, 2 loud frames (400) → speech_start pulse after frame 2 eval; speech_active=1. Then 1 quiet + 1 loud → no speech_end. Then 2 quiet → speech_end pulse; speech_active=0.
- 1 loud then 1 quiet frame → ONSET→SILENCE; no pulses; speech_active never rises.
- Energy exactly equal to threshold (threshold=400) → treated as quiet.
- Assert rst after sample 2 of a frame → outputs 0 immediately (async); 4 new samples produce a full frame from scratch.
- Samples alternating 0/4095 with sample_valid every cycle, FRAME_LEN=256 → no accumulator wrap; frame_energy within 256·4095.
